// File: rtl/freq_meter_ctrl_pkg.sv
// ============================================================================
// Module   : freq_meter_ctrl_pkg
// Brief    : State encodings shared by the frequency-meter sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package freq_meter_ctrl_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_GATE   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_LATCH  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/freq_meter_ctrl_sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchronizer, asynchronous active-high reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/freq_meter_ctrl.sv
// ============================================================================
// Module   : freq_meter_ctrl
// Brief    : Gate/settle/latch sequencer for an external 8-bit ripple counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_meter_ctrl
    import freq_meter_ctrl_pkg::*;
#(
    parameter int GATE_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 2,
    parameter int TB_W          = 16
) (
    input  logic       CLK,
    input  logic       Rd,
    input  logic       start,
    input  logic       continuous,
    input  logic       abort,
    input  logic [7:0] cnt_q,
    input  logic       cnt_cout,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic [7:0] result,
    output logic       overflow,
    output logic       valid,
    output logic       busy
);

    localparam logic [TB_W-1:0] C_GATE_LAST   = TB_W'(GATE_CYCLES - 1);
    localparam logic [TB_W-1:0] C_SETTLE_LAST = TB_W'(SETTLE_CYCLES - 1);
    localparam logic [TB_W-1:0] C_TB_MAX      = '1;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [TB_W-1:0] r_tb;
    logic            w_cout_s;
    logic            r_cout_d;
    logic            r_wrap;
    logic            w_clr_nxt;
    logic            w_en_nxt;
    logic            w_busy_nxt;

    sync_2ff u_cout_sync (
        .clk (CLK),
        .rst (Rd),
        .i_d (cnt_cout),
        .o_q (w_cout_s)
    );

    always_ff @(posedge CLK or posedge Rd) begin
        if (Rd) r_state <= S_IDLE;
        else    r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start)                 w_next = S_CLEAR;
            S_CLEAR:                             w_next = S_GATE;
            S_GATE:   if (r_tb == C_GATE_LAST)   w_next = S_SETTLE;
            S_SETTLE: if (r_tb == C_SETTLE_LAST) w_next = S_LATCH;
            S_LATCH:  w_next = continuous ? S_CLEAR : S_IDLE;
            default:                             w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    // Outputs are decoded from the next state so the registered pins line up with r_state.
    always_comb begin
        w_clr_nxt  = (w_next == S_IDLE) || (w_next == S_CLEAR);
        w_en_nxt   = (w_next == S_GATE);
        w_busy_nxt = (w_next != S_IDLE);
    end

    always_ff @(posedge CLK or posedge Rd) begin
        if (Rd) begin
            cnt_clr  <= 1'b1;
            cnt_en   <= 1'b0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            result   <= 8'd0;
            overflow <= 1'b0;
            r_tb     <= '0;
            r_cout_d <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            cnt_clr  <= w_clr_nxt;
            cnt_en   <= w_en_nxt;
            busy     <= w_busy_nxt;
            valid    <= 1'b0;
            r_cout_d <= w_cout_s;

            if (w_next != r_state)   r_tb <= '0;
            else if (r_tb != C_TB_MAX) r_tb <= r_tb + TB_W'(1);

            // A falling synced carry means the counter rolled FF -> 00.
            if (abort || r_state == S_CLEAR)
                r_wrap <= 1'b0;
            else if ((r_state == S_GATE || r_state == S_SETTLE) && r_cout_d && !w_cout_s)
                r_wrap <= 1'b1;

            if (r_state == S_LATCH && !abort) begin
                result   <= cnt_q;
                overflow <= r_wrap;
                valid    <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_freq_meter_ctrl.sv
// ============================================================================
// Module   : tb_freq_meter_ctrl
// Brief    : Directed bench for freq_meter_ctrl with a ripple-counter model at CLK/4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_freq_meter_ctrl;

    logic       CLK = 1'b0;
    logic       Rd = 1'b1;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cnt_q;
    logic       cnt_cout;
    logic       cnt_clr, cnt_en, overflow, valid, busy;
    logic [7:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n, valid_cnt, valid_at, en_cnt;
    int vt [3];
    int vi;

    // Counted signal: CLK/4, high while ph[1]; counter model advances on rising edges of sig & cnt_en.
    logic [1:0] ph = 2'd0;
    logic [7:0] mq = 8'd0;
    logic       g_old = 1'b0;
    logic       preload = 1'b0;
    logic       g;

    freq_meter_ctrl #(.GATE_CYCLES(10), .SETTLE_CYCLES(2), .TB_W(16)) dut (
        .CLK(CLK), .Rd(Rd), .start(start), .continuous(continuous), .abort(abort),
        .cnt_q(cnt_q), .cnt_cout(cnt_cout), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
        .result(result), .overflow(overflow), .valid(valid), .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) ph <= ph + 2'd1;

    always @(posedge CLK) begin
        #2;
        g = ph[1] & cnt_en;
        if (cnt_clr) mq = 8'd0;
        else if (preload) begin
            mq = 8'hFE;
            preload = 1'b0;
        end
        if (g && !g_old) mq = mq + 8'd1;
        g_old = g;
    end

    assign cnt_q    = mq;
    assign cnt_cout = (mq == 8'hFF);

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        edge_n++;
        if (valid === 1'b1) begin
            valid_cnt++;
            valid_at = edge_n;
        end
        if (cnt_en === 1'b1) en_cnt++;
    endtask

    // Presents start so it is sampled at edge 0 with the counted signal at a fixed phase.
    task automatic begin_run(input bit hold);
        @(negedge CLK);
        for (int i = 0; i < 4 && ph != 2'd3; i++) @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        edge_n = 0; valid_cnt = 0; valid_at = -1; en_cnt = 0;
        if (!hold) start = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_clr", cnt_clr, 1);
        check("rst_en", cnt_en, 0);
        check("rst_result", result, 0);
        check("rst_ovf", overflow, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        @(negedge CLK); Rd = 1'b0;
        repeat (3) @(negedge CLK);

        // 1: single run
        begin_run(0);
        check("t1_busy_clear", busy, 1);
        check("t1_clr_clear", cnt_clr, 1);
        step();
        check("t1_en_rise", cnt_en, 1);
        check("t1_clr_gate", cnt_clr, 0);
        repeat (9) step();
        check("t1_en_last", cnt_en, 1);
        step();
        check("t1_en_fall", cnt_en, 0);
        repeat (2) step();
        check("t1_valid_early", valid, 0);
        step();
        check("t1_valid", valid, 1);
        check("t1_result", result, 3);
        check("t1_ovf", overflow, 0);
        step();
        check("t1_valid_pulse", valid, 0);
        check("t1_busy_end", busy, 0);
        check("t1_en_cycles", en_cnt, 10);
        check("t1_valid_cnt", valid_cnt, 1);

        // 2: overflow run
        preload = 1'b1;
        begin_run(0);
        repeat (15) step();
        check("t2_valid_at", valid_at, 14);
        check("t2_result", result, 1);
        check("t2_ovf", overflow, 1);

        // 3: continuous, three runs
        continuous = 1'b1;
        begin_run(0);
        vi = 0;
        for (int n = 1; n <= 43; n++) begin
            step();
            if (valid === 1'b1 && vi < 3) begin
                vt[vi] = edge_n;
                vi++;
            end
            if (edge_n == 30) continuous = 1'b0;
            if (edge_n == 13 || edge_n == 27) check("t3_clr_before", cnt_clr, 0);
            if (edge_n == 14 || edge_n == 28) check("t3_clr_between", cnt_clr, 1);
            if (edge_n == 15 || edge_n == 29) check("t3_clr_after", cnt_clr, 0);
            if (edge_n == 14 || edge_n == 28 || edge_n == 42) check("t3_result", result, 3);
        end
        check("t3_valid_cnt", valid_cnt, 3);
        check("t3_first_valid", vt[0], 14);
        check("t3_spacing1", vt[1] - vt[0], 14);
        check("t3_spacing2", vt[2] - vt[1], 14);
        check("t3_busy_end", busy, 0);

        // 4: abort in gate cycle 5
        begin_run(0);
        repeat (5) step();
        check("t4_en_pre", cnt_en, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_en", cnt_en, 0);
        check("t4_clr", cnt_clr, 1);
        repeat (16) step();
        check("t4_no_valid", valid_cnt, 0);
        check("t4_result_kept", result, 3);
        check("t4_ovf_kept", overflow, 0);

        // 5: Rd mid-settle, between clocks
        begin_run(0);
        repeat (12) step();
        #2;
        Rd = 1'b1;
        #1;
        check("t5_clr", cnt_clr, 1);
        check("t5_en", cnt_en, 0);
        check("t5_result", result, 0);
        check("t5_ovf", overflow, 0);
        check("t5_valid", valid, 0);
        check("t5_busy", busy, 0);
        @(negedge CLK); Rd = 1'b0;
        begin_run(0);
        repeat (15) step();
        check("t5_rerun_valid_at", valid_at, 14);
        check("t5_rerun_result", result, 3);

        // 6: start held while busy, then start with abort in IDLE
        begin_run(1);
        repeat (12) step();
        check("t6_busy_held", busy, 1);
        start = 1'b0;
        repeat (4) step();
        check("t6_valid_cnt", valid_cnt, 1);
        check("t6_valid_at", valid_at, 14);
        check("t6_busy_end", busy, 0);
        @(negedge CLK);
        start = 1'b1;
        abort = 1'b1;
        step();
        check("t6_sa_busy", busy, 0);
        check("t6_sa_clr", cnt_clr, 1);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) step();
        check("t6_idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
